// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the boot loader.
// The loader uses the slave view; the host/link side uses master.
interface imem_loader_if #(
  parameter int ADDR_W = 12
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Serial boot loader: parses a length-prefixed, XOR-checksummed byte stream
// into 32-bit instruction-memory writes while holding the CPU in reset.
module imem_loader #(
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  imem_loader_if.slave       bus,
  output logic               cpu_rst,
  output logic               done,
  output logic               err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [15:0]       r_len;
  logic [15:0]       r_word_idx;
  logic [1:0]        r_byte_cnt;
  logic [7:0]        r_csum;
  logic [23:0]       r_asm;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_cpu_rst;
  logic              r_done;
  logic              r_err;

  logic              w_ready;
  logic              w_accept;
  logic              w_restart;
  logic [15:0]       w_len;
  logic              w_len_zero;
  logic              w_len_bad;
  logic              w_word_done;
  logic              w_last_word;

  assign w_ready = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                   (r_state == S_DATA)   || (r_state == S_CHECK);
  assign w_accept  = bus.byte_valid && w_ready;
  assign w_restart = start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                               (r_state == S_ERR));

  assign w_len       = {r_len[15:8], bus.byte_data};
  assign w_len_zero  = (w_len == 16'd0);
  assign w_len_bad   = ({1'b0, w_len} > 17'(DEPTH));
  assign w_word_done = w_accept && (r_state == S_DATA) && (r_byte_cnt == 2'd3);
  assign w_last_word = ((r_word_idx + 16'd1) == r_len);

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (start) w_next = S_LEN_HI;
      S_LEN_HI: if (w_accept) w_next = S_LEN_LO;
      S_LEN_LO: begin
        if (w_accept) begin
          if (w_len_zero)     w_next = S_CHECK;
          else if (w_len_bad) w_next = S_ERR;
          else                w_next = S_DATA;
        end
      end
      S_DATA:  if (w_word_done && w_last_word) w_next = S_CHECK;
      S_CHECK: begin
        if (w_accept) w_next = (bus.byte_data == r_csum) ? S_DONE : S_ERR;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_len      <= '0;
      r_word_idx <= '0;
      r_byte_cnt <= '0;
      r_csum     <= '0;
      r_asm      <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cpu_rst  <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (w_restart) begin
        r_word_idx <= '0;
        r_byte_cnt <= '0;
        r_csum     <= '0;
        r_cpu_rst  <= 1'b1;
        r_done     <= 1'b0;
        r_err      <= 1'b0;
      end
      if (w_accept) begin
        case (r_state)
          S_LEN_HI: r_len[15:8] <= bus.byte_data;
          S_LEN_LO: begin
            r_len[7:0] <= bus.byte_data;
            if (!w_len_zero && w_len_bad) r_err <= 1'b1;
          end
          S_DATA: begin
            // Only the three older bytes are kept; the fourth goes straight into wdata.
            r_asm      <= {r_asm[15:0], bus.byte_data};
            r_csum     <= r_csum ^ bus.byte_data;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_we       <= 1'b1;
              r_wdata    <= {r_asm, bus.byte_data};
              r_addr     <= r_word_idx[ADDR_W-1:0];
              r_word_idx <= r_word_idx + 16'd1;
            end
          end
          S_CHECK: begin
            if (bus.byte_data == r_csum) begin
              r_done    <= 1'b1;
              r_cpu_rst <= 1'b0;
            end else begin
              r_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // A write strobe still registered when reset arrives must not reach memory.
  assign bus.imem_we    = r_we && rst;
  assign bus.byte_ready = w_ready;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  assign cpu_rst        = r_cpu_rst;
  assign done           = r_done;
  assign err            = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad checksum, empty and oversize loads,
// throttled stream, and mid-session reset recovery.
module tb_imem_loader;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic cpu_rst;
  logic done;
  logic err;

  int checks = 0;
  int errors = 0;
  int stalls = 0;

  logic [7:0]  stim[$];
  logic [31:0] exp_d[$];
  logic [11:0] wq_addr[$];
  logic [31:0] wq_data[$];

  imem_loader_if #(.ADDR_W(12)) bus ();

  imem_loader #(.DEPTH(4096), .ADDR_W(12)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bus     (bus),
    .cpu_rst (cpu_rst),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      wq_addr.push_back(bus.imem_addr);
      wq_data.push_back(bus.imem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (bus.byte_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n > 0) stalls++;
    check("byte_ready", {31'b0, bus.byte_ready}, 32'd1);
    if (bus.byte_ready === 1'b1) @(posedge clk);
    #1 bus.byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic build_stim(input logic [15:0] n, input logic [7:0] cs);
    stim.delete();
    stim.push_back(n[15:8]);
    stim.push_back(n[7:0]);
    foreach (exp_d[i]) begin
      stim.push_back(exp_d[i][31:24]);
      stim.push_back(exp_d[i][23:16]);
      stim.push_back(exp_d[i][15:8]);
      stim.push_back(exp_d[i][7:0]);
    end
    stim.push_back(cs);
  endtask

  // gaps: random idle cycles before each byte; pulse_at: index before which
  // a stray start pulse is injected (-1 for none)
  task automatic send_stim(input bit gaps, input int pulse_at);
    foreach (stim[i]) begin
      if (i == pulse_at) pulse_start();
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      send_byte(stim[i]);
    end
  endtask

  task automatic check_writes(input string tag, input int n);
    check({tag, "_wr_count"}, 32'(wq_data.size()), 32'(n));
    for (int i = 0; i < n && i < wq_data.size(); i++) begin
      check({tag, "_wr_addr"}, 32'(wq_addr[i]), 32'(i));
      check({tag, "_wr_data"}, wq_data[i], exp_d[i]);
    end
  endtask

  task automatic check_end(input string tag, input logic d, input logic e, input logic c);
    @(negedge clk);
    check({tag, "_done"},    {31'b0, done},           {31'b0, d});
    check({tag, "_err"},     {31'b0, err},            {31'b0, e});
    check({tag, "_cpu_rst"}, {31'b0, cpu_rst},        {31'b0, c});
    check({tag, "_ready"},   {31'b0, bus.byte_ready}, 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ready",   {31'b0, bus.byte_ready}, 32'd0);
    check("rst_cpu_rst", {31'b0, cpu_rst},        32'd1);
    check("rst_done",    {31'b0, done},           32'd0);
    check("rst_err",     {31'b0, err},            32'd0);
    check("rst_we",      {31'b0, bus.imem_we},    32'd0);
    check("rst_addr",    32'(bus.imem_addr),      32'd0);
    check("rst_wdata",   bus.imem_wdata,          32'd0);
    rst = 1'b1;

    // Byte offered while idle must be ignored
    @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hA5;
    repeat (3) @(negedge clk);
    check("idle_ready", {31'b0, bus.byte_ready}, 32'd0);
    check("idle_nowr",  32'(wq_data.size()),     32'd0);
    bus.byte_valid = 1'b0;

    // Good load, back-to-back bytes
    exp_d.delete();
    exp_d.push_back(32'h3C010001);
    exp_d.push_back(32'h00000000);
    build_stim(16'd2, 8'h3C);
    wq_addr.delete(); wq_data.delete();
    pulse_start();
    check("start_cpu_rst", {31'b0, cpu_rst}, 32'd1);
    stalls = 0;
    send_stim(1'b0, -1);
    check("good_nostall", 32'(stalls), 32'd0);
    check_end("good", 1'b0 + 1'b1, 1'b0, 1'b0);
    check_writes("good", 2);

    // Same data, wrong checksum
    build_stim(16'd2, 8'h3D);
    wq_addr.delete(); wq_data.delete();
    pulse_start();
    check("restart_done_clr", {31'b0, done}, 32'd0);
    send_stim(1'b0, -1);
    check_end("badcs", 1'b0, 1'b1, 1'b1);
    check_writes("badcs", 2);

    // Empty load
    exp_d.delete();
    build_stim(16'd0, 8'h00);
    wq_addr.delete(); wq_data.delete();
    pulse_start();
    send_stim(1'b0, -1);
    check_end("empty", 1'b1, 1'b0, 1'b0);
    check_writes("empty", 0);

    // Oversize length: error right after LEN_LO, further bytes refused
    pulse_start();
    send_byte(8'h10);
    send_byte(8'h01);
    check_end("over", 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hAA;
    repeat (3) @(negedge clk);
    check("over_refuse", {31'b0, bus.byte_ready}, 32'd0);
    check("over_nowr",   32'(wq_data.size()),     32'd0);
    bus.byte_valid = 1'b0;

    // Length exactly DEPTH is legal
    pulse_start();
    send_byte(8'h10);
    send_byte(8'h00);
    @(negedge clk);
    check("maxlen_err",   {31'b0, err},            32'd0);
    check("maxlen_ready", {31'b0, bus.byte_ready}, 32'd1);

    // Throttled stream with a stray start mid-session
    exp_d.delete();
    exp_d.push_back(32'h3C010001);
    exp_d.push_back(32'h00000000);
    build_stim(16'd2, 8'h3C);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    wq_addr.delete(); wq_data.delete();
    pulse_start();
    send_stim(1'b1, 5);
    check_end("gaps", 1'b1, 1'b0, 1'b0);
    check_writes("gaps", 2);

    // Reset after 6 data bytes of N=4
    exp_d.delete();
    exp_d.push_back(32'h01020304);
    wq_addr.delete(); wq_data.delete();
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h04);
    for (int i = 1; i <= 6; i++) send_byte(8'(i));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_writes("midrst", 1);
    check("midrst_ready",   {31'b0, bus.byte_ready}, 32'd0);
    check("midrst_cpu_rst", {31'b0, cpu_rst},        32'd1);
    check("midrst_addr",    32'(bus.imem_addr),      32'd0);
    check("midrst_wdata",   bus.imem_wdata,          32'd0);

    // Fresh load after reset starts again at address 0
    exp_d.delete();
    exp_d.push_back(32'h11223344);
    exp_d.push_back(32'hAABBCCDD);
    build_stim(16'd2, 8'h44);
    wq_addr.delete(); wq_data.delete();
    pulse_start();
    send_stim(1'b0, -1);
    check_end("reload", 1'b1, 1'b0, 1'b0);
    check_writes("reload", 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
